// File: rtl/ifu_pf.sv
// Prefetching instruction fetch unit: issues aligned fetch-block requests with up to
// DEPTH credits shared between in-flight requests and buffered blocks; drops stale data on redirect.
module ifu_pf #(
    parameter int                  PC_WIDTH = 30,
    parameter int                  FW_LOG2  = 2,
    parameter int                  DEPTH    = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                          i_Clk,
    input  logic                          i_RstN,
    output logic                          o_FetchV,
    output logic [PC_WIDTH-FW_LOG2-1:0]   o_FetchA,
    input  logic                          i_FetchR,
    input  logic                          i_RspV,
    input  logic [(32<<FW_LOG2)-1:0]      i_RspD,
    input  logic                          i_JumpV,
    input  logic [PC_WIDTH-1:0]           i_JumpT,
    output logic                          o_InstrV,
    output logic [(32<<FW_LOG2)-1:0]      o_InstrD,
    output logic [FW_LOG2-1:0]            o_InstrSel,
    input  logic                          i_InstrR,
    output logic                          o_ProtErr
);
    localparam int BW = PC_WIDTH - FW_LOG2;
    localparam int DW = 32 << FW_LOG2;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [CW-1:0]       infl_q, infl_d, drop_q, drop_d, cnt_q, cnt_d;
    logic [AW-1:0]       twp_q, twp_d, trp_q, trp_d;
    logic [AW-1:0]       bwp_q, bwp_d, brp_q, brp_d;
    logic                prot_q, prot_d;

    logic [FW_LOG2-1:0]  tag_mem  [DEPTH];
    logic [DW-1:0]       bdat_mem [DEPTH];
    logic [FW_LOG2-1:0]  bsel_mem [DEPTH];

    logic                acc, rsp_ok, keep, pop;
    logic [CW:0]         used;

    assign used     = {1'b0, infl_q} + {1'b0, cnt_q};
    assign o_FetchV = i_RstN & ~i_JumpV & (used < (CW+1)'(DEPTH));
    assign o_FetchA = pc_q[PC_WIDTH-1:FW_LOG2];
    assign acc      = o_FetchV & i_FetchR;
    assign rsp_ok   = i_RspV & (infl_q != '0);
    // A response counts as live only when no stale ones remain and no redirect is flushing.
    assign keep     = rsp_ok & (drop_q == '0) & ~i_JumpV;
    assign pop      = o_InstrV & i_InstrR;

    assign o_InstrV   = (cnt_q != '0);
    assign o_InstrD   = bdat_mem[brp_q];
    assign o_InstrSel = o_InstrV ? bsel_mem[brp_q] : '0;
    assign o_ProtErr  = prot_q;

    always_comb begin
        pc_d   = pc_q;
        infl_d = infl_q;
        drop_d = drop_q;
        cnt_d  = cnt_q;
        twp_d  = twp_q;
        trp_d  = trp_q;
        bwp_d  = bwp_q;
        brp_d  = brp_q;
        prot_d = prot_q;
        if (acc) begin
            pc_d  = {pc_q[PC_WIDTH-1:FW_LOG2] + BW'(1), {FW_LOG2{1'b0}}};
            twp_d = twp_q + AW'(1);
        end
        // Stale tags stay queued across a redirect so late stale responses still retire them.
        if (rsp_ok)
            trp_d = trp_q + AW'(1);
        if (i_RspV && !rsp_ok)
            prot_d = 1'b1;
        if (i_JumpV) begin
            pc_d   = i_JumpT;
            infl_d = infl_q - CW'(rsp_ok);
            drop_d = infl_q - CW'(rsp_ok);
            cnt_d  = '0;
            bwp_d  = '0;
            brp_d  = '0;
        end else begin
            infl_d = infl_q + CW'(acc) - CW'(rsp_ok);
            if (rsp_ok && drop_q != '0)
                drop_d = drop_q - CW'(1);
            if (keep)
                bwp_d = bwp_q + AW'(1);
            if (pop)
                brp_d = brp_q + AW'(1);
            cnt_d = cnt_q + CW'(keep) - CW'(pop);
        end
    end

    always_ff @(posedge i_Clk or negedge i_RstN) begin
        if (!i_RstN) begin
            pc_q   <= RESET_PC;
            infl_q <= '0;
            drop_q <= '0;
            cnt_q  <= '0;
            twp_q  <= '0;
            trp_q  <= '0;
            bwp_q  <= '0;
            brp_q  <= '0;
            prot_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            infl_q <= infl_d;
            drop_q <= drop_d;
            cnt_q  <= cnt_d;
            twp_q  <= twp_d;
            trp_q  <= trp_d;
            bwp_q  <= bwp_d;
            brp_q  <= brp_d;
            prot_q <= prot_d;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (acc)
            tag_mem[twp_q] <= pc_q[FW_LOG2-1:0];
        if (keep) begin
            bdat_mem[bwp_q] <= i_RspD;
            bsel_mem[bwp_q] <= tag_mem[trp_q];
        end
    end
endmodule

// File: tb/tb_ifu_pf.sv
// Directed bench for ifu_pf: credit flow, backpressure, redirects, address wrap, protocol error.
module tb_ifu_pf;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         fetch_v;
    logic [27:0]  fetch_a;
    logic         fetch_r;
    logic         rsp_v;
    logic [127:0] rsp_d;
    logic         jump_v;
    logic [29:0]  jump_t;
    logic         instr_v;
    logic [127:0] instr_d;
    logic [1:0]   instr_sel;
    logic         instr_r;
    logic         prot_err;

    int n_vec = 0;
    int n_err = 0;

    ifu_pf #(.PC_WIDTH(30), .FW_LOG2(2), .DEPTH(4), .RESET_PC(30'h0)) dut (
        .i_Clk(clk), .i_RstN(rst_n),
        .o_FetchV(fetch_v), .o_FetchA(fetch_a), .i_FetchR(fetch_r),
        .i_RspV(rsp_v), .i_RspD(rsp_d),
        .i_JumpV(jump_v), .i_JumpT(jump_t),
        .o_InstrV(instr_v), .o_InstrD(instr_d), .o_InstrSel(instr_sel), .i_InstrR(instr_r),
        .o_ProtErr(prot_err)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] dat(input int a);
        return {32'hCAFE0000 ^ 32'(a), 32'(a), ~32'(a), 32'h12340000 | 32'(a)};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; fetch_r = 1'b0; rsp_v = 1'b0; rsp_d = '0;
        jump_v = 1'b0; jump_t = '0; instr_r = 1'b0;
        #2;
        n_vec++; if (fetch_v !== 1'b0) begin n_err++; $display("FAIL reset_fetchv got %b exp 0", fetch_v); end
        n_vec++; if (instr_v !== 1'b0) begin n_err++; $display("FAIL reset_instrv got %b exp 0", instr_v); end
        n_vec++; if (instr_sel !== 2'd0) begin n_err++; $display("FAIL reset_sel got %0d exp 0", instr_sel); end
        n_vec++; if (prot_err !== 1'b0) begin n_err++; $display("FAIL reset_prot got %b exp 0", prot_err); end
        step;
        rst_n = 1'b1;
        #1;
        n_vec++; if (fetch_v !== 1'b1 || fetch_a !== 28'h0) begin n_err++; $display("FAIL reset_release got v=%b a=%h exp v=1 a=0", fetch_v, fetch_a); end
    endtask

    task automatic test_stream;
        fetch_r = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (fetch_v !== 1'b1 || fetch_a !== 28'(i)) begin n_err++; $display("FAIL stream_issue%0d got v=%b a=%h exp v=1 a=%h", i, fetch_v, fetch_a, i); end
            step;
        end
        rsp_v = 1'b1; rsp_d = dat(0); instr_r = 1'b1;
        #1;
        n_vec++; if (fetch_v !== 1'b0) begin n_err++; $display("FAIL stream_credit got %b exp 0", fetch_v); end
        n_vec++; if (instr_v !== 1'b0) begin n_err++; $display("FAIL stream_nobypass got %b exp 0", instr_v); end
        step;
        rsp_d = dat(1);
        #1;
        n_vec++; if (instr_v !== 1'b1 || instr_d !== dat(0) || instr_sel !== 2'd0) begin n_err++; $display("FAIL stream_blk0 got v=%b d=%h sel=%0d exp 1 %h 0", instr_v, instr_d, instr_sel, dat(0)); end
        n_vec++; if (fetch_v !== 1'b0) begin n_err++; $display("FAIL stream_still_full got %b exp 0", fetch_v); end
        step;
        rsp_d = dat(2);
        #1;
        n_vec++; if (instr_d !== dat(1)) begin n_err++; $display("FAIL stream_blk1 got %h exp %h", instr_d, dat(1)); end
        n_vec++; if (fetch_v !== 1'b1 || fetch_a !== 28'h4) begin n_err++; $display("FAIL stream_resume got v=%b a=%h exp v=1 a=4", fetch_v, fetch_a); end
        step;
        rsp_d = dat(3); fetch_r = 1'b0;
        #1;
        n_vec++; if (instr_d !== dat(2)) begin n_err++; $display("FAIL stream_blk2 got %h exp %h", instr_d, dat(2)); end
        n_vec++; if (fetch_v !== 1'b1 || fetch_a !== 28'h5) begin n_err++; $display("FAIL stream_next got v=%b a=%h exp v=1 a=5", fetch_v, fetch_a); end
        step;
        rsp_d = dat(4);
        #1;
        n_vec++; if (instr_d !== dat(3)) begin n_err++; $display("FAIL stream_blk3 got %h exp %h", instr_d, dat(3)); end
        step;
        rsp_v = 1'b0;
        #1;
        n_vec++; if (instr_v !== 1'b1 || instr_d !== dat(4)) begin n_err++; $display("FAIL stream_blk4 got v=%b d=%h exp 1 %h", instr_v, instr_d, dat(4)); end
        step;
        instr_r = 1'b0;
        #1;
        n_vec++; if (instr_v !== 1'b0) begin n_err++; $display("FAIL stream_empty got %b exp 0", instr_v); end
    endtask

    task automatic test_backpressure;
        fetch_r = 1'b1; instr_r = 1'b0;
        for (int i = 5; i < 9; i++) begin
            n_vec++; if (fetch_v !== 1'b1 || fetch_a !== 28'(i)) begin n_err++; $display("FAIL bp_issue%0d got v=%b a=%h exp v=1 a=%h", i, fetch_v, fetch_a, i); end
            step;
            rsp_v = 1'b1; rsp_d = dat(i);
            #1;
        end
        n_vec++; if (fetch_v !== 1'b0) begin n_err++; $display("FAIL bp_full got %b exp 0", fetch_v); end
        step;
        rsp_v = 1'b0;
        #1;
        n_vec++; if (fetch_v !== 1'b0 || instr_v !== 1'b1 || instr_d !== dat(5)) begin n_err++; $display("FAIL bp_hold got fv=%b iv=%b d=%h exp 0 1 %h", fetch_v, instr_v, instr_d, dat(5)); end
        step;
        instr_r = 1'b1;
        #1;
        n_vec++; if (fetch_v !== 1'b0) begin n_err++; $display("FAIL bp_stays_off got %b exp 0", fetch_v); end
        step;
        instr_r = 1'b0;
        #1;
        n_vec++; if (fetch_v !== 1'b1 || fetch_a !== 28'h9) begin n_err++; $display("FAIL bp_one_credit got v=%b a=%h exp v=1 a=9", fetch_v, fetch_a); end
        step;
        fetch_r = 1'b0; rsp_v = 1'b1; rsp_d = dat(9);
        #1;
        n_vec++; if (fetch_v !== 1'b0) begin n_err++; $display("FAIL bp_exactly_one got %b exp 0", fetch_v); end
        step;
        rsp_v = 1'b0; instr_r = 1'b1;
        for (int i = 6; i < 10; i++) begin
            #1;
            n_vec++; if (instr_v !== 1'b1 || instr_d !== dat(i)) begin n_err++; $display("FAIL bp_drain%0d got v=%b d=%h exp 1 %h", i, instr_v, instr_d, dat(i)); end
            step;
        end
        instr_r = 1'b0;
        #1;
        n_vec++; if (instr_v !== 1'b0) begin n_err++; $display("FAIL bp_empty got %b exp 0", instr_v); end
    endtask

    task automatic test_jump;
        fetch_r = 1'b1;
        for (int i = 10; i < 14; i++) step;
        fetch_r = 1'b0; rsp_v = 1'b1; rsp_d = dat(10);
        step;
        rsp_v = 1'b0; jump_v = 1'b1; jump_t = 30'h102; fetch_r = 1'b1; instr_r = 1'b1;
        #1;
        n_vec++; if (fetch_v !== 1'b0 || instr_v !== 1'b1) begin n_err++; $display("FAIL jump_cycle got fv=%b iv=%b exp 0 1", fetch_v, instr_v); end
        step;
        jump_v = 1'b0; instr_r = 1'b0; rsp_v = 1'b1; rsp_d = dat(11);
        #1;
        n_vec++; if (instr_v !== 1'b0) begin n_err++; $display("FAIL jump_flush got %b exp 0", instr_v); end
        n_vec++; if (fetch_v !== 1'b1 || fetch_a !== 28'h40) begin n_err++; $display("FAIL jump_target got v=%b a=%h exp v=1 a=40", fetch_v, fetch_a); end
        step;
        rsp_d = dat(12);
        #1;
        n_vec++; if (fetch_v !== 1'b1 || fetch_a !== 28'h41) begin n_err++; $display("FAIL jump_seq got v=%b a=%h exp v=1 a=41", fetch_v, fetch_a); end
        step;
        fetch_r = 1'b0; rsp_d = dat(13);
        step;
        rsp_d = dat(32'h40);
        #1;
        n_vec++; if (instr_v !== 1'b0) begin n_err++; $display("FAIL jump_stale_dropped got %b exp 0", instr_v); end
        step;
        rsp_d = dat(32'h41); instr_r = 1'b1;
        #1;
        n_vec++; if (instr_v !== 1'b1 || instr_sel !== 2'd2 || instr_d !== dat(32'h40)) begin n_err++; $display("FAIL jump_first got v=%b sel=%0d d=%h exp 1 2 %h", instr_v, instr_sel, instr_d, dat(32'h40)); end
        step;
        rsp_v = 1'b0;
        #1;
        n_vec++; if (instr_v !== 1'b1 || instr_sel !== 2'd0 || instr_d !== dat(32'h41)) begin n_err++; $display("FAIL jump_second got v=%b sel=%0d d=%h exp 1 0 %h", instr_v, instr_sel, instr_d, dat(32'h41)); end
        step;
        instr_r = 1'b0;
        #1;
        n_vec++; if (instr_v !== 1'b0) begin n_err++; $display("FAIL jump_empty got %b exp 0", instr_v); end
    endtask

    task automatic test_jump_rsp;
        fetch_r = 1'b1;
        #1;
        n_vec++; if (fetch_a !== 28'h42) begin n_err++; $display("FAIL jrsp_start got %h exp 42", fetch_a); end
        step;
        step;
        fetch_r = 1'b0; jump_v = 1'b1; jump_t = 30'h200; rsp_v = 1'b1; rsp_d = dat(32'h42);
        step;
        jump_v = 1'b0; fetch_r = 1'b1; rsp_d = dat(32'h43);
        #1;
        n_vec++; if (fetch_v !== 1'b1 || fetch_a !== 28'h80) begin n_err++; $display("FAIL jrsp_target got v=%b a=%h exp v=1 a=80", fetch_v, fetch_a); end
        step;
        fetch_r = 1'b0; rsp_d = dat(32'h80);
        #1;
        n_vec++; if (instr_v !== 1'b0) begin n_err++; $display("FAIL jrsp_dropped got %b exp 0", instr_v); end
        step;
        rsp_v = 1'b0;
        #1;
        n_vec++; if (instr_v !== 1'b1 || instr_sel !== 2'd0 || instr_d !== dat(32'h80)) begin n_err++; $display("FAIL jrsp_block got v=%b sel=%0d d=%h exp 1 0 %h", instr_v, instr_sel, instr_d, dat(32'h80)); end
        instr_r = 1'b1;
        step;
        instr_r = 1'b0;
    endtask

    task automatic test_wrap;
        jump_v = 1'b1; jump_t = 30'h300;
        #1;
        n_vec++; if (fetch_v !== 1'b0) begin n_err++; $display("FAIL wrap_jump1 got %b exp 0", fetch_v); end
        step;
        jump_t = 30'h3FFFFFFD;
        step;
        jump_v = 1'b0; fetch_r = 1'b1;
        #1;
        n_vec++; if (fetch_v !== 1'b1 || fetch_a !== 28'hFFFFFFF) begin n_err++; $display("FAIL wrap_last_target got v=%b a=%h exp v=1 a=fffffff", fetch_v, fetch_a); end
        step;
        fetch_r = 1'b0; rsp_v = 1'b1; rsp_d = dat(32'h0FFFFFFF);
        #1;
        n_vec++; if (fetch_v !== 1'b1 || fetch_a !== 28'h0) begin n_err++; $display("FAIL wrap_addr got v=%b a=%h exp v=1 a=0", fetch_v, fetch_a); end
        step;
        rsp_v = 1'b0;
        #1;
        n_vec++; if (instr_v !== 1'b1 || instr_sel !== 2'd1 || instr_d !== dat(32'h0FFFFFFF)) begin n_err++; $display("FAIL wrap_block got v=%b sel=%0d d=%h exp 1 1 %h", instr_v, instr_sel, instr_d, dat(32'h0FFFFFFF)); end
        instr_r = 1'b1;
        step;
        instr_r = 1'b0;
    endtask

    task automatic test_proterr;
        rsp_v = 1'b1; rsp_d = dat(99);
        #1;
        n_vec++; if (prot_err !== 1'b0) begin n_err++; $display("FAIL perr_before got %b exp 0", prot_err); end
        step;
        rsp_v = 1'b0;
        #1;
        n_vec++; if (prot_err !== 1'b1) begin n_err++; $display("FAIL perr_set got %b exp 1", prot_err); end
        n_vec++; if (instr_v !== 1'b0 || fetch_v !== 1'b1 || fetch_a !== 28'h0) begin n_err++; $display("FAIL perr_state got iv=%b fv=%b a=%h exp 0 1 0", instr_v, fetch_v, fetch_a); end
        step;
        n_vec++; if (prot_err !== 1'b1) begin n_err++; $display("FAIL perr_sticky got %b exp 1", prot_err); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (prot_err !== 1'b0 || fetch_v !== 1'b0) begin n_err++; $display("FAIL perr_async_reset got pe=%b fv=%b exp 0 0", prot_err, fetch_v); end
        step;
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset;
        test_stream;
        test_backpressure;
        test_jump;
        test_jump_rsp;
        test_wrap;
        test_proterr;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ifu_pf.md
Name: ifu_pf

Overview:
Parametrised prefetching instruction fetch unit, the successor to the single-request fetch stage. Issues aligned fetch-block requests to the instruction memory port, keeping up to DEPTH requests in flight. Buffers in-order responses with their drop-select tag for the decode FIFO. On a redirect it discards stale in-flight responses and flushes the buffer.

Parameters:
PC_WIDTH, 30, word-address PC width.
FW_LOG2, 2, log2 of words per fetch block (2 gives 4 x 32 = 128-bit blocks).
DEPTH, 4, max in-flight requests plus buffered blocks; power of 2, at least 2.
RESET_PC, 0, PC loaded at reset (PC_WIDTH bits).

Ports:
i_Clk  in  1  core clock, single clock domain.
i_RstN  in  1  asynchronous active-low reset.
o_FetchV  out  1  fetch request valid.
o_FetchA  out  PC_WIDTH-FW_LOG2  fetch block address, r_PC[PC_WIDTH-1:FW_LOG2].
i_FetchR  in  1  memory accepts the request when o_FetchV & i_FetchR.
i_RspV  in  1  response valid, in order, one per accepted request.
i_RspD  in  32<<FW_LOG2  response block data.
i_JumpV  in  1  redirect valid.
i_JumpT  in  PC_WIDTH  redirect target word address.
o_InstrV  out  1  buffered block available.
o_InstrD  out  32<<FW_LOG2  head block data.
o_InstrSel  out  FW_LOG2  number of leading words of the head block to drop.
i_InstrR  in  1  consumer pops head when o_InstrV & i_InstrR.
o_ProtErr  out  1  sticky flag: a response arrived with nothing in flight.

Behaviour:
- Reset (async, asserted): r_PC=RESET_PC; inflight=0; drop_cnt=0; buffer count=0; o_FetchV=0; o_InstrV=0; o_InstrSel=0; o_ProtErr=0.
- Credit rule: o_FetchV = !i_JumpV & (inflight + buf_cnt < DEPTH). The combinational dependence on i_JumpV is intended: no request is issued in a redirect cycle.
- Accept (o_FetchV & i_FetchR):
  - r_PC <= {r_PC[PC_WIDTH-1:FW_LOG2]+1, 0}; the block address wraps modulo 2^(PC_WIDTH-FW_LOG2).
  - Push tag = r_PC[FW_LOG2-1:0] into the in-order tag FIFO (DEPTH entries).
  - inflight++.
- Response (i_RspV with inflight>0):
  - Pop the tag FIFO and decrement inflight.
  - If drop_cnt>0: discard the response and decrement drop_cnt.
  - Otherwise write {i_RspD, tag} to the output buffer (DEPTH entries). It is visible on o_InstrV the next cycle (1-cycle latency, no bypass).
- Response with inflight==0: ignored, and o_ProtErr <= 1 (sticky until reset).
- Accept and response in the same cycle: inflight unchanged, tag FIFO pushes and pops.
- Output buffer: o_InstrV = buf_cnt!=0; o_InstrD/o_InstrSel come from the head. A pop and a write in the same cycle keep buf_cnt unchanged. The credit rule guarantees the buffer never overflows.
- Redirect (i_JumpV), which has priority over all other state updates:
  - r_PC <= i_JumpT.
  - buf_cnt <= 0 (flush); any pop in this cycle is discarded.
  - drop_cnt <= inflight - i_RspV. Every request already in flight is stale; a response arriving in the jump cycle is itself discarded.
  - The tag FIFO keeps its stale entries so later stale responses still pop them.
  - First fetch after the redirect carries tag = i_JumpT[FW_LOG2-1:0]; later sequential fetches carry tag 0.
  - Back-to-back jumps: each recomputes drop_cnt from the current inflight. The last target wins.
- Counter widths: inflight, drop_cnt and buf_cnt are clog2(DEPTH+1) bits. drop_cnt <= inflight is always true.
- Reset mid-operation: all state is cleared immediately. Responses arriving after reset with inflight==0 set o_ProtErr.

Test Plan:
- Reset release, RESET_PC=0, i_FetchR=1, 1-cycle memory: o_FetchA = 0,1,2,3 on consecutive cycles, then o_FetchV drops once DEPTH=4 credits are used. With i_InstrR=1, blocks arrive with o_InstrSel=0 and fetching resumes.
- i_InstrR=0, memory responds to every request: after 4 accepts o_FetchV=0 and stays 0. buf_cnt=4, no overflow. One pop re-enables exactly one fetch.
- 3 requests in flight, i_JumpV with i_JumpT=0x102: o_FetchV=0 that cycle and the buffer is flushed. The 3 stale responses are dropped. The next o_FetchA=0x40 with resulting o_InstrSel=2, then 0x41 with sel 0.
- i_JumpV and i_RspV in the same cycle with inflight=2: that response and 1 more are dropped. The first response of a post-jump request appears on o_InstrV.
- r_PC block address all-ones, accepted request: next o_FetchA=0, no X.
- i_RspV with inflight=0: o_ProtErr=1 and stays 1; buffer and counters unchanged. Assert i_RstN low: o_ProtErr=0 immediately.
